// File: rtl/fib_sched_pkg.sv
// fib_sched_pkg: FSM state type, reset values and engine seed constants
// shared by the Fibonacci run scheduler and its term engine.
`default_nettype none

package fib_sched_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam state_t STATE_RST = IDLE;
  localparam logic   OVF_RST   = 1'b0;

  // Seeds loaded on every clear so each run starts 0, 1, 1, 2, ...
  localparam int A0 = 0;
  localparam int B0 = 1;

endpackage

`default_nettype wire

// File: rtl/fib_core.sv
// fib_core: two-register Fibonacci term engine with sticky wrap tracking.
// term is the current term a; ovf marks that a's true value exceeds 2^WIDTH-1.
`default_nettype none

module fib_core
  import fib_sched_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  output logic [WIDTH-1:0] term,
  output logic             ovf
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ovf_a;
  logic             ovf_b;
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, a} + {1'b0, b};

  // b is one term ahead of a, so its wrap flag becomes a's flag one step later.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      a     <= WIDTH'(A0);
      b     <= WIDTH'(B0);
      ovf_a <= OVF_RST;
      ovf_b <= OVF_RST;
    end else if (step) begin
      a     <= b;
      b     <= sum[WIDTH-1:0];
      ovf_b <= sum[WIDTH] | ovf_a | ovf_b;
      ovf_a <= ovf_b;
    end
  end

  assign term = a;
  assign ovf  = ovf_a;

endmodule

`default_nettype wire

// File: rtl/fib_sched.sv
// fib_sched: round-robin scheduler sharing one Fibonacci engine among
// NUM_REQ requesters; streams tagged terms on a valid/ready port.
`default_nettype none

module fib_sched
  import fib_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 32,
  parameter  int CNT_W   = 8,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*CNT_W-1:0] req_count,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [ID_W-1:0]          out_id,
  output logic                     out_last,
  output logic                     out_ovf,
  output logic                     busy
);

  state_t           state;
  state_t           next_state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  id;
  logic [CNT_W-1:0] remaining;

  logic             any_req;
  logic [ID_W-1:0]  gidx;
  logic [CNT_W-1:0] gcount;
  logic             accept;
  logic             fire;
  logic             last;
  logic [WIDTH-1:0] term;
  logic             term_ovf;

  // Walk offsets from NUM_REQ down to 1 so the nearest requester after rr_ptr wins.
  always_comb begin
    any_req = 1'b0;
    gidx    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req_valid[ID_W'((int'(rr_ptr) + i) % NUM_REQ)]) begin
        any_req = 1'b1;
        gidx    = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  assign gcount = req_count[int'(gidx)*CNT_W +: CNT_W];
  assign accept = (state == IDLE) && any_req;
  assign last   = (remaining == CNT_W'(1));
  assign fire   = (state == RUN) && out_ready;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gidx] = 1'b1;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= STATE_RST;
    else     state <= next_state;
  end

  // FSM: next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && gcount != '0) next_state = RUN;
      RUN:     if (fire && last)           next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM: output decode; payload is forced to zero outside RUN
  always_comb begin
    out_valid = (state == RUN);
    busy      = (state == RUN);
    out_data  = out_valid ? term     : '0;
    out_id    = out_valid ? id       : '0;
    out_last  = out_valid ? last     : 1'b0;
    out_ovf   = out_valid ? term_ovf : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      id        <= '0;
      remaining <= '0;
    end else if (accept) begin
      rr_ptr    <= gidx;
      id        <= gidx;
      remaining <= gcount;
    end else if (fire) begin
      remaining <= remaining - CNT_W'(1);
    end
  end

  fib_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .step (fire),
    .term (term),
    .ovf  (term_ovf)
  );

endmodule

`default_nettype wire

// File: tb/tb_fib_sched.sv
// tb_fib_sched: table-driven check of fib_sched (WIDTH=32) plus hand-written
// backpressure, overflow (WIDTH=8 instance) and mid-run reset sequences.
`default_nettype none

module tb_fib_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_count;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_id;
  logic        out_last;
  logic        out_ovf;
  logic        busy;

  logic [3:0]  rv8;
  logic [31:0] cnt8;
  logic [3:0]  rdy8;
  logic        vld8;
  logic        ordy8;
  logic [7:0]  data8;
  logic [1:0]  id8;
  logic        last8;
  logic        ovf8;
  logic        busy8;

  always #5 clk = ~clk;

  fib_sched #(.NUM_REQ(4), .WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_count(req_count),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .out_last(out_last),
    .out_ovf(out_ovf), .busy(busy)
  );

  fib_sched #(.NUM_REQ(4), .WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .req_valid(rv8), .req_count(cnt8),
    .req_ready(rdy8), .out_valid(vld8), .out_ready(ordy8),
    .out_data(data8), .out_id(id8), .out_last(last8),
    .out_ovf(ovf8), .busy(busy8)
  );

  typedef struct {
    logic [3:0]  rv;
    logic [31:0] cnt;
    logic        ordy;
    logic [3:0]  rdy;
    logic        vld;
    logic [31:0] data;
    logic [1:0]  id;
    logic        last;
    logic        busy;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] rv, input logic [31:0] cnt, input logic [3:0] rdy,
                     input logic vld, input logic [31:0] data, input logic [1:0] id,
                     input logic last);
    vec_t v;
    v.rv = rv; v.cnt = cnt; v.ordy = 1'b1; v.rdy = rdy; v.vld = vld;
    v.data = data; v.id = id; v.last = last; v.busy = vld;
    vq.push_back(v);
  endtask

  function automatic logic [63:0] pack_main();
    return {22'd0, req_ready, out_valid, out_data, out_id, out_last, out_ovf, busy};
  endfunction

  longint fib[16];

  initial begin
    logic [3:0] pat;
    int k;
    longint fa, fb, t;

    fa = 0; fb = 1;
    for (int i = 0; i < 16; i++) begin
      fib[i] = fa; t = fa + fb; fa = fb; fb = t;
    end

    // Round robin from reset: grants 0,1,2,3,0 with count 2 each.
    for (int g = 0; g < 5; g++) begin
      add(4'hF, 32'h0202_0202, 4'b0001 << (g % 4), 1'b0, 32'd0, 2'd0, 1'b0);
      add(4'hF, 32'h0202_0202, 4'b0000, 1'b1, 32'd0, 2'(g % 4), 1'b0);
      add(4'hF, 32'h0202_0202, 4'b0000, 1'b1, 32'd1, 2'(g % 4), 1'b1);
    end
    // Single run from requester 0, count 8.
    add(4'b0001, 32'd8, 4'b0001, 1'b0, 32'd0, 2'd0, 1'b0);
    for (int i = 0; i < 8; i++)
      add(4'b0000, 32'd8, 4'b0000, 1'b1, 32'(fib[i]), 2'd0, i == 7);
    add(4'b0000, 32'd0, 4'b0000, 1'b0, 32'd0, 2'd0, 1'b0);
    // Zero count on requester 1 followed by count 3 on requester 2.
    add(4'b0110, 32'h0003_0000, 4'b0010, 1'b0, 32'd0, 2'd0, 1'b0);
    add(4'b0100, 32'h0003_0000, 4'b0100, 1'b0, 32'd0, 2'd0, 1'b0);
    add(4'b0000, 32'h0003_0000, 4'b0000, 1'b1, 32'd0, 2'd2, 1'b0);
    add(4'b0000, 32'h0003_0000, 4'b0000, 1'b1, 32'd1, 2'd2, 1'b0);
    add(4'b0000, 32'h0003_0000, 4'b0000, 1'b1, 32'd1, 2'd2, 1'b1);
    add(4'b0000, 32'd0, 4'b0000, 1'b0, 32'd0, 2'd0, 1'b0);

    rst = 1'b1; req_valid = '0; req_count = '0; out_ready = 1'b1;
    rv8 = '0; cnt8 = '0; ordy8 = 1'b1;
    step(); step();
    chk("reset_outputs", pack_main(), 64'd0);
    chk("reset_outputs8", {rdy8, vld8, data8, id8, last8, ovf8, busy8}, 64'd0);
    rst = 1'b0;

    foreach (vq[i]) begin
      req_valid = vq[i].rv; req_count = vq[i].cnt; out_ready = vq[i].ordy;
      #1;
      chk($sformatf("vec%0d", i), pack_main(),
          {22'd0, vq[i].rdy, vq[i].vld, vq[i].data, vq[i].id, vq[i].last, 1'b0, vq[i].busy});
      step();
    end

    // Backpressure: out_ready pattern 1,0,0,1 repeating.
    req_valid = 4'b0001; req_count = 32'd8; out_ready = 1'b1;
    #1;
    chk("bp_accept", {60'd0, req_ready}, 64'b0001);
    step();
    req_valid = '0;
    pat = 4'b1001; k = 0;
    for (int c = 0; c < 60 && k < 8; c++) begin
      out_ready = pat[c % 4];
      #1;
      chk($sformatf("bp_term%0d", k), {out_valid, out_data, out_id, out_last, out_ovf},
          {1'b1, 32'(fib[k]), 2'd0, k == 7, 1'b0});
      if (out_ready) k++;
      step();
    end
    chk("bp_count", 64'(k), 64'd8);
    chk("bp_idle", {62'd0, out_valid, busy}, 64'd0);
    out_ready = 1'b1;

    // Overflow on the 8-bit instance: count 16.
    rv8 = 4'b0001; cnt8 = 32'd16;
    #1;
    chk("ovf_accept", {60'd0, rdy8}, 64'b0001);
    step();
    rv8 = '0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("ovf_term%0d", i), {vld8, data8, last8, ovf8},
          {1'b1, 8'(fib[i] % 256), i == 15, fib[i] >= 256});
      step();
    end
    chk("ovf_idle", {63'd0, vld8}, 64'd0);

    // Reset during the 4th term of a count-8 run.
    req_valid = 4'b0001; req_count = 32'd8;
    step();
    req_valid = '0;
    step(); step(); step();
    rst = 1'b1;
    #1;
    chk("rst_mid_term", {out_valid, out_data}, {1'b1, 32'd2});
    step();
    chk("rst_mid_after", {30'd0, out_valid, busy, out_data}, 64'd0);
    rst = 1'b0;
    req_valid = 4'b1001; req_count = 32'h0100_0001;
    #1;
    chk("rst_grant0", {60'd0, req_ready}, 64'b0001);
    step();
    req_valid = 4'b1000;
    #1;
    chk("rst_run0", {out_valid, out_data, out_id, out_last, req_ready},
        {1'b1, 32'd0, 2'd0, 1'b1, 4'b0000});
    step();
    #1;
    chk("rst_grant3", {60'd0, req_ready}, 64'b1000);
    step();
    req_valid = '0;
    #1;
    chk("rst_run3", {out_valid, out_data, out_id, out_last}, {1'b1, 32'd0, 2'd3, 1'b1});
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
